bus_mem_arbiter: RTL and testbench
==================================

# bus_mem_arbiter

Two-port arbiter that shares the single 64-bit Avalon-style burst memory port between two bus masters, e.g. the instruction fetch and data ports. It sits in front of the bus/memory clock-domain crossing and runs entirely in the bus clock domain. It grants one master at a time, forwards that master's command and write beats, and tracks read bursts beat by beat. Returned read data is routed to the master that issued the burst.

## Interface
- ROUND_ROBIN, 1: 1 = alternate winner on contention; 0 = fixed priority, m0 always wins ties.
- i_bus_clock  in  1  single clock, all logic on rising edge.
- i_bus_reset  in  1  asynchronous, active-high reset.
- i_mN_address  in  32  master N address (N = 0, 1 for all mN ports).
- i_mN_be  in  8  byte enables.
- i_mN_read_req  in  1  read request.
- i_mN_write_req  in  1  write request / write beat strobe.
- i_mN_burst_count  in  8  burst length in beats.
- i_mN_burst_begin  in  1  first-beat marker.
- i_mN_write_data  in  64  write data.
- o_mN_read_data  out  64  read data; i_mem_read_data broadcast to both masters.
- o_mN_read_data_valid  out  1  read beat valid, asserted only to the owning master.
- o_mN_wait_request  out  1  stall to master N.
- o_mem_address, o_mem_be, o_mem_read_req, o_mem_write_req, o_mem_burst_count, o_mem_burst_begin, o_mem_write_data  out  32/8/1/1/8/1/64  memory command, muxed from the granted master.
- i_mem_read_data  in  64, i_mem_read_data_valid  in  1, i_mem_wait_request  in  1  memory response and stall.
- o_grant  out  2  one-hot current grant; 00 when idle.
- o_busy  out  1  state != IDLE.

## Operation
- States: IDLE, READ_CMD, READ_DATA, WRITE.
- IDLE
  - Memory outputs are 0 and both o_mN_wait_request = 1.
  - A master is requesting when read_req | write_req is asserted.
  - One requester: grant it.
  - Both requesting, ROUND_ROBIN=1: grant the master that is not last_served. ROUND_ROBIN=0: grant m0.
  - Next state is READ_CMD if the winner's read_req is set, otherwise WRITE. read_req takes precedence if both are set.
- Muxing (all states except IDLE)
  - Memory command outputs = granted master's inputs, combinational.
  - Granted o_mN_wait_request = i_mem_wait_request, except in READ_DATA where it is 1.
  - Non-granted o_mN_wait_request = 1.
- READ_CMD
  - Accept occurs when read_req & !i_mem_wait_request.
  - On accept: beat_cnt <= burst_count, with 0 treated as 1; go to READ_DATA.
  - If the granted master drops read_req and write_req before accept: go to IDLE and update last_served.
- READ_DATA
  - o_mem_read_req = 0.
  - Each i_mem_read_data_valid is forwarded to the owner and decrements beat_cnt.
  - On the valid with beat_cnt==1: go to IDLE and set last_served = owner.
- WRITE
  - Each write_req & !i_mem_wait_request is one accepted beat.
  - The first accepted beat latches beat_cnt = burst_count (0→1) minus 1.
  - Later beats decrement beat_cnt.
  - The beat that leaves 0 remaining returns the state to IDLE and updates last_served.
  - A deassert before the first accept returns to IDLE. A deassert mid-burst holds the state.
- i_mem_read_data_valid outside READ_DATA is dropped; no master sees valid.
- beat_cnt is 8 bits unsigned. A 255-beat burst needs no wrap.

## Timing
- Reset values:
  - State IDLE, beat_cnt 0, last_served = m1 (m0 wins the first tie).
  - o_grant 00, o_busy 0.
  - All memory outputs 0; all o_mN_read_data_valid 0; all o_mN_wait_request 1.
- Arbitration latency:
  - A request seen in IDLE at cycle N gives grant and memory command visible at N+1.
  - The earliest accept is at N+1.
- Burst end:
  - The last read valid or last write accept at cycle M puts the state in IDLE at M+1.
  - The next grant is visible at M+2; one idle cycle between bursts.
- Read data path is combinational: owner's valid and data appear in the same cycle as i_mem_read_data_valid, with no added latency.
- Reset asserted mid-burst forces the reset values immediately. Remaining memory beats are dropped.
- A new request arriving during READ_DATA or WRITE is held off by wait_request=1 and considered at the next IDLE.

## Test plan
- Single read: m0 read, address 0x100, burst 4. Memory accepts at once and returns 4 valids → m0 gets 4 valids; m1 valid stays 0; o_grant=01 → 00 one cycle after the 4th beat.
- Contention with ROUND_ROBIN=1: m0 and m1 both request single reads at the same time, three times in a row → grant order m0, m1, m0. With ROUND_ROBIN=0 → m0, m0, m0 while m0 keeps requesting.
- Write burst with stalls: m1 writes 3 beats of 0xA5.., i_mem_wait_request high on beat 2 for 2 cycles → o_m1_wait_request mirrors the stall; exactly 3 beats are accepted; m0 wait_request stays 1 throughout.
- burst_count=0 read: exactly 1 valid ends the burst → IDLE.
- Stray response: i_mem_read_data_valid pulsed in IDLE → neither master sees valid; state is unchanged.
- Reset mid-burst: assert i_bus_reset after 2 of 8 read beats → outputs return to reset values asynchronously; after release, m0 wins the first tie.

Source files
------------

// File: rtl/bus_mem_arbiter_if.sv
// One Avalon-style 64-bit burst port. A bus master and a memory sit on either side of it.
// The master modport issues commands and receives read data and stalls.
// The slave modport accepts commands and returns read data and stalls.
interface bus_mem_arbiter_if;
    logic [31:0] address;
    logic [7:0]  be;
    logic        read_req;
    logic        write_req;
    logic [7:0]  burst_count;
    logic        burst_begin;
    logic [63:0] write_data;
    logic [63:0] read_data;
    logic        read_data_valid;
    logic        wait_request;

    modport master (
        output address, be, read_req, write_req, burst_count, burst_begin, write_data,
        input  read_data, read_data_valid, wait_request
    );

    modport slave (
        input  address, be, read_req, write_req, burst_count, burst_begin, write_data,
        output read_data, read_data_valid, wait_request
    );
endinterface

// File: rtl/bus_mem_arbiter.sv
// Shares one 64-bit burst memory port between two bus masters (m0 and m1).
// A single master is granted for the whole burst. Its command and its write beats
// pass straight through to memory. Read beats are counted, and each one is steered
// to the master that issued the burst.
module bus_mem_arbiter #(
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic                     i_bus_clock,
    input  logic                     i_bus_reset,
    bus_mem_arbiter_if.slave         io_m0,
    bus_mem_arbiter_if.slave         io_m1,
    bus_mem_arbiter_if.master        io_mem,
    output logic [1:0]               o_grant,
    output logic                     o_busy
);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_READ_CMD  = 2'd1;
    localparam logic [1:0] ST_READ_DATA = 2'd2;
    localparam logic [1:0] ST_WRITE     = 2'd3;

    logic [1:0] r_state;
    logic       r_owner;        // 0 = m0, 1 = m1; meaningful outside IDLE
    logic       r_last_served;  // master that most recently finished or abandoned
    logic [7:0] r_beat_cnt;
    logic       r_wr_started;   // first write beat of the burst has been accepted

    logic        w_m0_req;
    logic        w_m1_req;
    logic        w_winner;
    logic        w_winner_read;
    logic [31:0] w_sel_address;
    logic [7:0]  w_sel_be;
    logic        w_sel_read;
    logic        w_sel_write;
    logic [7:0]  w_sel_burst_count;
    logic        w_sel_burst_begin;
    logic [63:0] w_sel_write_data;
    logic [7:0]  w_burst_len;
    logic        w_owner_wait;
    logic        w_accept;

    assign w_m0_req = io_m0.read_req | io_m0.write_req;
    assign w_m1_req = io_m1.read_req | io_m1.write_req;

    // Pick the winner in IDLE. On a tie, round robin favours the master that was not served last.
    always_comb begin
        w_winner = 1'b0;
        if (w_m0_req && w_m1_req) begin
            w_winner = (ROUND_ROBIN != 1'b0) ? ~r_last_served : 1'b0;
        end else if (w_m1_req) begin
            w_winner = 1'b1;
        end
    end

    assign w_winner_read = w_winner ? io_m1.read_req : io_m0.read_req;

    // Select the command signals of the current owner.
    assign w_sel_address     = r_owner ? io_m1.address     : io_m0.address;
    assign w_sel_be          = r_owner ? io_m1.be          : io_m0.be;
    assign w_sel_read        = r_owner ? io_m1.read_req    : io_m0.read_req;
    assign w_sel_write       = r_owner ? io_m1.write_req   : io_m0.write_req;
    assign w_sel_burst_count = r_owner ? io_m1.burst_count : io_m0.burst_count;
    assign w_sel_burst_begin = r_owner ? io_m1.burst_begin : io_m0.burst_begin;
    assign w_sel_write_data  = r_owner ? io_m1.write_data  : io_m0.write_data;

    // A burst count of zero is treated as a single beat.
    assign w_burst_len = (w_sel_burst_count == 8'd0) ? 8'd1 : w_sel_burst_count;

    // Drive the memory command. The bus is quiet in IDLE, and read_req is suppressed
    // while beats are being returned.
    always_comb begin
        io_mem.address     = 32'd0;
        io_mem.be          = 8'd0;
        io_mem.read_req    = 1'b0;
        io_mem.write_req   = 1'b0;
        io_mem.burst_count = 8'd0;
        io_mem.burst_begin = 1'b0;
        io_mem.write_data  = 64'd0;
        if (r_state != ST_IDLE) begin
            io_mem.address     = w_sel_address;
            io_mem.be          = w_sel_be;
            io_mem.read_req    = w_sel_read && (r_state != ST_READ_DATA);
            io_mem.write_req   = w_sel_write;
            io_mem.burst_count = w_sel_burst_count;
            io_mem.burst_begin = w_sel_burst_begin;
            io_mem.write_data  = w_sel_write_data;
        end
    end

    // The owner sees the memory stall, or a forced stall while its read data drains.
    // Any master that is not the owner is always stalled.
    assign w_owner_wait       = (r_state == ST_READ_DATA) ? 1'b1 : io_mem.wait_request;
    assign io_m0.wait_request = ((r_state != ST_IDLE) && !r_owner) ? w_owner_wait : 1'b1;
    assign io_m1.wait_request = ((r_state != ST_IDLE) &&  r_owner) ? w_owner_wait : 1'b1;

    // Read data goes to both masters. Valid goes only to the owner, and only while
    // its burst is draining.
    assign io_m0.read_data       = io_mem.read_data;
    assign io_m1.read_data       = io_mem.read_data;
    assign io_m0.read_data_valid = io_mem.read_data_valid && (r_state == ST_READ_DATA) && !r_owner;
    assign io_m1.read_data_valid = io_mem.read_data_valid && (r_state == ST_READ_DATA) &&  r_owner;

    assign o_grant = (r_state == ST_IDLE) ? 2'b00 : (r_owner ? 2'b10 : 2'b01);
    assign o_busy  = (r_state != ST_IDLE);

    assign w_accept = !io_mem.wait_request;

    // Arbitration and burst-tracking state machine.
    always_ff @(posedge i_bus_clock or posedge i_bus_reset) begin
        if (i_bus_reset) begin
            r_state       <= ST_IDLE;
            r_owner       <= 1'b0;
            r_last_served <= 1'b1;
            r_beat_cnt    <= 8'd0;
            r_wr_started  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_wr_started <= 1'b0;
                    if (w_m0_req || w_m1_req) begin
                        r_owner <= w_winner;
                        r_state <= w_winner_read ? ST_READ_CMD : ST_WRITE;
                    end
                end
                ST_READ_CMD: begin
                    if (w_sel_read && w_accept) begin
                        r_beat_cnt <= w_burst_len;
                        r_state    <= ST_READ_DATA;
                    end else if (!w_sel_read && !w_sel_write) begin
                        r_state       <= ST_IDLE;
                        r_last_served <= r_owner;
                    end
                end
                ST_READ_DATA: begin
                    if (io_mem.read_data_valid) begin
                        r_beat_cnt <= r_beat_cnt - 8'd1;
                        if (r_beat_cnt == 8'd1) begin
                            r_state       <= ST_IDLE;
                            r_last_served <= r_owner;
                        end
                    end
                end
                ST_WRITE: begin
                    if (w_sel_write && w_accept) begin
                        if (!r_wr_started) begin
                            r_wr_started <= 1'b1;
                            r_beat_cnt   <= w_burst_len - 8'd1;
                            if (w_burst_len == 8'd1) begin
                                r_state       <= ST_IDLE;
                                r_last_served <= r_owner;
                            end
                        end else begin
                            r_beat_cnt <= r_beat_cnt - 8'd1;
                            if (r_beat_cnt == 8'd1) begin
                                r_state       <= ST_IDLE;
                                r_last_served <= r_owner;
                            end
                        end
                    end else if (!w_sel_write && !r_wr_started) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_mem_arbiter.sv
// Scoreboard bench for bus_mem_arbiter. One round-robin instance and one
// fixed-priority instance see the same stimulus. A negedge monitor pops the
// expected grants, read beats and write beats whenever the DUT presents one.
module tb_bus_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bus_mem_arbiter_if m0_if ();
    bus_mem_arbiter_if m1_if ();
    bus_mem_arbiter_if mem_if ();
    bus_mem_arbiter_if f_m0 ();
    bus_mem_arbiter_if f_m1 ();
    bus_mem_arbiter_if f_mem ();

    logic [1:0] grant, f_grant;
    logic       busy, f_busy;

    bus_mem_arbiter #(.ROUND_ROBIN(1'b1)) dut (
        .i_bus_clock(clk), .i_bus_reset(rst),
        .io_m0(m0_if), .io_m1(m1_if), .io_mem(mem_if),
        .o_grant(grant), .o_busy(busy)
    );

    bus_mem_arbiter #(.ROUND_ROBIN(1'b0)) dut_fixed (
        .i_bus_clock(clk), .i_bus_reset(rst),
        .io_m0(f_m0), .io_m1(f_m1), .io_mem(f_mem),
        .o_grant(f_grant), .o_busy(f_busy)
    );

    // The fixed-priority instance mirrors every input of the main instance.
    assign f_m0.address = m0_if.address;   assign f_m1.address = m1_if.address;
    assign f_m0.be = m0_if.be;             assign f_m1.be = m1_if.be;
    assign f_m0.read_req = m0_if.read_req; assign f_m1.read_req = m1_if.read_req;
    assign f_m0.write_req = m0_if.write_req; assign f_m1.write_req = m1_if.write_req;
    assign f_m0.burst_count = m0_if.burst_count; assign f_m1.burst_count = m1_if.burst_count;
    assign f_m0.burst_begin = m0_if.burst_begin; assign f_m1.burst_begin = m1_if.burst_begin;
    assign f_m0.write_data = m0_if.write_data;   assign f_m1.write_data = m1_if.write_data;
    assign f_mem.read_data = mem_if.read_data;
    assign f_mem.read_data_valid = mem_if.read_data_valid;
    assign f_mem.wait_request = mem_if.wait_request;

    int n_checks = 0;
    int n_errors = 0;

    logic [1:0]  exp_grant[$];
    logic [1:0]  exp_fgrant[$];
    logic [64:0] exp_rd[$];     // {owner, data}
    logic [63:0] exp_wr[$];
    logic [1:0]  prev_g, prev_fg;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got 0x%0h expected no event", name, act);
    endtask

    // Monitor: compare each DUT output event against the scoreboard queues.
    initial begin
        prev_g  = 2'b00;
        prev_fg = 2'b00;
        forever begin
            @(negedge clk);
            if (grant != 2'b00 && prev_g == 2'b00) begin
                $display("txn grant rr=%b", grant);
                if (exp_grant.size() == 0) unexpected("grant_rr", grant);
                else check("grant_rr", grant, exp_grant.pop_front());
            end
            if (f_grant != 2'b00 && prev_fg == 2'b00) begin
                $display("txn grant fixed=%b", f_grant);
                if (exp_fgrant.size() == 0) unexpected("grant_fixed", f_grant);
                else check("grant_fixed", f_grant, exp_fgrant.pop_front());
            end
            prev_g  = grant;
            prev_fg = f_grant;
            if (m0_if.read_data_valid && m1_if.read_data_valid) begin
                unexpected("rd_both_valid", 64'd3);
            end else if (m0_if.read_data_valid || m1_if.read_data_valid) begin
                logic [64:0] got;
                got = {m1_if.read_data_valid,
                       m1_if.read_data_valid ? m1_if.read_data : m0_if.read_data};
                $display("txn read beat m%0d data=0x%0h", got[64], got[63:0]);
                if (exp_rd.size() == 0) unexpected("rd_beat", got[63:0]);
                else check("rd_beat", {63'd0, got} , {63'd0, exp_rd.pop_front()});
            end
            if (mem_if.write_req && !mem_if.wait_request) begin
                $display("txn write beat data=0x%0h", mem_if.write_data);
                if (exp_wr.size() == 0) unexpected("wr_beat", mem_if.write_data);
                else check("wr_beat", mem_if.write_data, exp_wr.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_if.address = 0; m0_if.be = 0; m0_if.read_req = 0; m0_if.write_req = 0;
        m0_if.burst_count = 0; m0_if.burst_begin = 0; m0_if.write_data = 0;
        m1_if.address = 0; m1_if.be = 0; m1_if.read_req = 0; m1_if.write_req = 0;
        m1_if.burst_count = 0; m1_if.burst_begin = 0; m1_if.write_data = 0;
        mem_if.read_data = 0; mem_if.read_data_valid = 0; mem_if.wait_request = 0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_grant"}, grant, 2'b00);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_mem_addr"}, mem_if.address, 0);
        check({tag, "_mem_be"}, mem_if.be, 0);
        check({tag, "_mem_rd"}, mem_if.read_req, 0);
        check({tag, "_mem_wr"}, mem_if.write_req, 0);
        check({tag, "_mem_bc"}, mem_if.burst_count, 0);
        check({tag, "_mem_bb"}, mem_if.burst_begin, 0);
        check({tag, "_mem_wd"}, mem_if.write_data, 0);
        check({tag, "_m0_wait"}, m0_if.wait_request, 1'b1);
        check({tag, "_m1_wait"}, m1_if.wait_request, 1'b1);
        check({tag, "_m0_valid"}, m0_if.read_data_valid, 1'b0);
        check({tag, "_m1_valid"}, m1_if.read_data_valid, 1'b0);
        check({tag, "_fgrant"}, f_grant, 2'b00);
    endtask

    initial begin
        logic [63:0] d;
        clear_inputs();
        rst = 1'b1;
        repeat (3) tick();
        check_reset_values("rst");
        rst = 1'b0;
        tick();

        // Single read: m0, address 0x100, burst of 4.
        m0_if.address = 32'h100; m0_if.be = 8'hFF; m0_if.burst_count = 8'd4;
        m0_if.burst_begin = 1'b1; m0_if.read_req = 1'b1;
        exp_grant.push_back(2'b01); exp_fgrant.push_back(2'b01);
        tick();
        check("rd_mem_addr", mem_if.address, 32'h100);
        check("rd_mem_req", mem_if.read_req, 1'b1);
        check("rd_mem_bc", mem_if.burst_count, 8'd4);
        check("rd_m0_wait", m0_if.wait_request, 1'b0);
        check("rd_m1_wait", m1_if.wait_request, 1'b1);
        tick();
        m0_if.read_req = 1'b0; m0_if.burst_begin = 1'b0;
        #1;
        check("rd_data_m0_wait", m0_if.wait_request, 1'b1);
        check("rd_data_mem_req", mem_if.read_req, 1'b0);
        for (int i = 0; i < 4; i++) begin
            d = 64'h1000 + 64'(i);
            mem_if.read_data = d; mem_if.read_data_valid = 1'b1;
            exp_rd.push_back({1'b0, d});
            #1;
            check("rd_grant_during", grant, 2'b01);
            check("rd_m1_valid", m1_if.read_data_valid, 1'b0);
            tick();
        end
        mem_if.read_data_valid = 1'b0;
        #1;
        check("rd_end_grant", grant, 2'b00);
        tick();

        // Write burst: m1 sends 3 beats; memory stalls beat 2 for two cycles.
        m1_if.address = 32'h200; m1_if.be = 8'hFF; m1_if.burst_count = 8'd3;
        m1_if.burst_begin = 1'b1; m1_if.write_req = 1'b1;
        m1_if.write_data = 64'hA5A5_A5A5_A5A5_A501;
        exp_grant.push_back(2'b10); exp_fgrant.push_back(2'b10);
        tick();
        exp_wr.push_back(64'hA5A5_A5A5_A5A5_A501);
        check("wr_b1_m1_wait", m1_if.wait_request, 1'b0);
        check("wr_b1_m0_wait", m0_if.wait_request, 1'b1);
        check("wr_mem_addr", mem_if.address, 32'h200);
        tick();
        m1_if.burst_begin = 1'b0; m1_if.write_data = 64'hA5A5_A5A5_A5A5_A502;
        mem_if.wait_request = 1'b1;
        #1;
        check("wr_stall1_m1_wait", m1_if.wait_request, 1'b1);
        check("wr_stall1_m0_wait", m0_if.wait_request, 1'b1);
        tick();
        check("wr_stall2_m1_wait", m1_if.wait_request, 1'b1);
        tick();
        mem_if.wait_request = 1'b0;
        exp_wr.push_back(64'hA5A5_A5A5_A5A5_A502);
        #1;
        check("wr_b2_m1_wait", m1_if.wait_request, 1'b0);
        tick();
        m1_if.write_data = 64'hA5A5_A5A5_A5A5_A503;
        exp_wr.push_back(64'hA5A5_A5A5_A5A5_A503);
        #1;
        check("wr_b3_m0_wait", m0_if.wait_request, 1'b1);
        tick();
        m1_if.write_req = 1'b0;
        #1;
        check("wr_end_grant", grant, 2'b00);
        check("wr_end_busy", busy, 1'b0);
        tick();

        // Burst count 0 read, followed by a stray valid in IDLE.
        m0_if.address = 32'h300; m0_if.burst_count = 8'd0;
        m0_if.burst_begin = 1'b1; m0_if.read_req = 1'b1;
        exp_grant.push_back(2'b01); exp_fgrant.push_back(2'b01);
        tick();
        check("bc0_mem_bc", mem_if.burst_count, 8'd0);
        tick();
        m0_if.read_req = 1'b0; m0_if.burst_begin = 1'b0;
        mem_if.read_data = 64'hBEEF; mem_if.read_data_valid = 1'b1;
        exp_rd.push_back({1'b0, 64'hBEEF});
        tick();
        mem_if.read_data = 64'hDEAD;
        #1;
        check("stray_grant", grant, 2'b00);
        check("stray_busy", busy, 1'b0);
        check("stray_m0_valid", m0_if.read_data_valid, 1'b0);
        check("stray_m1_valid", m1_if.read_data_valid, 1'b0);
        tick();
        mem_if.read_data_valid = 1'b0;
        #1;
        check("stray_after_busy", busy, 1'b0);
        tick();

        // Reset asserted after 2 of 8 read beats.
        m0_if.address = 32'h400; m0_if.burst_count = 8'd8;
        m0_if.burst_begin = 1'b1; m0_if.read_req = 1'b1;
        exp_grant.push_back(2'b01); exp_fgrant.push_back(2'b01);
        tick();
        tick();
        m0_if.read_req = 1'b0; m0_if.burst_begin = 1'b0;
        for (int i = 0; i < 2; i++) begin
            d = 64'h4000 + 64'(i);
            mem_if.read_data = d; mem_if.read_data_valid = 1'b1;
            exp_rd.push_back({1'b0, d});
            tick();
        end
        mem_if.read_data = 64'h4002;
        rst = 1'b1;
        #1;
        check_reset_values("rstmid");
        tick();
        mem_if.read_data_valid = 1'b0;
        tick();
        rst = 1'b0;

        // Contention: both masters hold single-beat read requests for three bursts.
        m0_if.address = 32'h500; m0_if.burst_count = 8'd1; m0_if.burst_begin = 1'b1;
        m1_if.address = 32'h600; m1_if.burst_count = 8'd1; m1_if.burst_begin = 1'b1;
        m0_if.read_req = 1'b1; m1_if.read_req = 1'b1;
        for (int r = 0; r < 3; r++) begin
            logic win;
            win = (r == 1);
            exp_grant.push_back(win ? 2'b10 : 2'b01);
            exp_fgrant.push_back(2'b01);
            tick();
            tick();
            d = 64'h7000 + 64'(r);
            mem_if.read_data = d; mem_if.read_data_valid = 1'b1;
            exp_rd.push_back({win, d});
            tick();
            mem_if.read_data_valid = 1'b0;
        end
        m0_if.read_req = 1'b0; m1_if.read_req = 1'b0;
        repeat (3) tick();

        check("left_grant", 64'(exp_grant.size()), 0);
        check("left_fgrant", 64'(exp_fgrant.size()), 0);
        check("left_rd", 64'(exp_rd.size()), 0);
        check("left_wr", 64'(exp_wr.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
